des_sched: RTL and testbench



---
 rtl/des_pkg.sv | 21 ++
 rtl/des_sched_arb.sv | 45 ++++
 rtl/des_sched.sv | 133 +++++++++++++
 tb/tb_des_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types for the DES core scheduler: block type, tag record, tag-width helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package des_pkg;

    localparam int DES_W    = 64;
    // Tag id field is sized for the largest supported requester count (16).
    localparam int TAG_ID_W = 4;

    typedef logic [DES_W-1:0] des_blk_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } des_tag_t;

    function automatic int tag_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/des_sched_arb.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping mod N.
// Latency: combinational, gnt/idx/any follow req and ptr in the same cycle.
// Backpressure: none; a losing requester simply holds req until granted.
module des_sched_arb #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [N-1:0] req_hi;

    // Requests at or above the pointer take priority; the rest cover the wrap.
    always_comb begin
        req_hi = '0;
        for (int i = 0; i < N; i++) begin
            req_hi[i] = req[i] && (i >= int'(ptr));
        end
    end

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req_hi[i]) begin
                any    = 1'b1;
                idx    = IDW'(i);
                gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                idx    = IDW'(i);
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/des_sched.sv
// Round-robin sharing of one pipelined DES core among N requesters; err checker under DES_SCHED_CHECK_EN.
// Latency: LAT+2 cycles from grant to rsp_valid, fixed, one block per cycle aggregate.
// Backpressure: none toward the core; requesters hold req until gnt, results are never stalled.
module des_sched
    import des_pkg::*;
#(
    parameter int N   = 4,
    parameter int LAT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [DES_W*N-1:0] req_key,
    input  logic [DES_W*N-1:0] req_data,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       rsp_valid,
    output logic [DES_W-1:0]   rsp_data,
    output logic               core_invalid,
    output logic [DES_W-1:0]   core_id,
    output logic [DES_W-1:0]   core_key,
    input  logic               core_outvalid,
    input  logic [DES_W-1:0]   core_od,
    output logic               err
);

    localparam int IDW = tag_w(N);
    localparam int QW  = $clog2(LAT + 2);
    localparam logic [QW-1:0] QUIET_LD = QW'(LAT + 1);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;
    logic           any;
    des_blk_t       sel_key;
    des_blk_t       sel_data;
    des_tag_t       tag_line [LAT+1];
    des_tag_t       tag_out;
    logic [QW-1:0]  quiet_cnt;
    logic           quiet;
    logic           hit;

    des_sched_arb #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    always_comb begin
        sel_key  = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_key  = req_key[i*DES_W +: DES_W];
                sel_data = req_data[i*DES_W +: DES_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            core_invalid <= 1'b0;
            core_key     <= '0;
            core_id      <= '0;
        end else begin
            core_invalid <= any;
            if (any) begin
                core_key <= sel_key;
                core_id  <= sel_data;
                ptr      <= (idx == IDW'(N - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    // Stage k holds the tag of the block the core accepted k cycles ago,
    // so stage LAT lines up with core_outvalid for that block.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= LAT; s++) begin
                tag_line[s] <= '0;
            end
        end else begin
            tag_line[0] <= '{valid: any, id: TAG_ID_W'(idx)};
            for (int s = 1; s <= LAT; s++) begin
                tag_line[s] <= tag_line[s-1];
            end
        end
    end

    assign tag_out = tag_line[LAT];

    // The core itself is never reset, so its pipeline may still emit results
    // from before rst; ignore everything until those have drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            quiet_cnt <= QUIET_LD;
        end else if (quiet) begin
            quiet_cnt <= quiet_cnt - 1'b1;
        end
    end

    assign quiet = (quiet_cnt != '0);
    assign hit   = !quiet && tag_out.valid && core_outvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= hit ? (N'(1) << tag_out.id) : '0;
            if (hit) begin
                rsp_data <= core_od;
            end
        end
    end

`ifdef DES_SCHED_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (!quiet && (core_outvalid != tag_out.valid)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_des_sched.sv
// Directed bench for des_sched: vector table for arbitration plus hand sequences for DES result, reset and checker.
module tb_des_sched;

    localparam int N   = 4;
    localparam int LAT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [64*N-1:0] req_key;
    logic [64*N-1:0] req_data;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [63:0]     rsp_data;
    logic            core_invalid;
    logic [63:0]     core_id;
    logic [63:0]     core_key;
    logic            core_outvalid;
    logic [63:0]     core_od;
    logic            err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int drop_cyc = -1;
    bit mon_en = 1'b0;
    bit exp_err = 1'b0;
    logic [63:0] last_key = '0;
    logic [63:0] last_data = '0;

    typedef struct {
        int          cyc;
        logic [N-1:0] vld;
        logic [63:0] dat;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [N-1:0] r;
        logic [N-1:0] g;
    } vec_t;
    vec_t tbl [19];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    des_sched #(.N(N), .LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_key       (req_key),
        .req_data      (req_data),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .core_invalid  (core_invalid),
        .core_id       (core_id),
        .core_key      (core_key),
        .core_outvalid (core_outvalid),
        .core_od       (core_od),
        .err           (err)
    );

    // Core model: the known DES vector is looked up, other blocks get a cheap mix.
    function automatic logic [63:0] core_fn(input logic [63:0] k, input logic [63:0] d);
        if (k == 64'h133457799BBCDFF1 && d == 64'h0123456789ABCDEF)
            return 64'h85E813540F0AB405;
        return k ^ {d[31:0], d[63:32]};
    endfunction

    // Fixed-latency pipeline with no reset; can drop the block accepted in cycle drop_cyc.
    logic        mv [LAT];
    logic [63:0] md [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            mv[k] <= mv[k-1];
            md[k] <= md[k-1];
        end
        mv[0] <= core_invalid && (cyc != drop_cyc);
        md[0] <= core_fn(core_key, core_id);
    end
    assign core_outvalid = mv[LAT-1];
    assign core_od       = md[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, want);
        end
    endtask

    // Response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("rsp_valid", 64'(rsp_valid), 64'(exp_q[0].vld));
                chk("rsp_data", rsp_data, exp_q[0].dat);
                void'(exp_q.pop_front());
            end else begin
                chk("rsp_idle", 64'(rsp_valid), 64'd0);
            end
            chk("err", 64'(err), 64'(exp_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lane(input int seed, input int i, input bit is_key);
        logic [63:0] base;
        base = is_key ? 64'h5A5A_0000_0000_0000 : 64'h0F0F_0000_0000_0000;
        return base + (64'(seed) << 16) + 64'(i);
    endfunction

    task automatic set_lanes(input int seed);
        for (int i = 0; i < N; i++) begin
            req_key[i*64 +: 64]  = lane(seed, i, 1'b1);
            req_data[i*64 +: 64] = lane(seed, i, 1'b0);
        end
    endtask

    // One cycle: present r, check the grant, then check what reached the core port.
    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] eg,
                         input bit do_rst, input bit keep);
        int gi;
        gi  = -1;
        req = r;
        #1;
        chk("gnt", 64'(gnt), 64'(eg));
        for (int i = 0; i < N; i++) if (eg[i]) gi = i;
        if (gi >= 0 && !do_rst) begin
            last_key  = req_key[gi*64 +: 64];
            last_data = req_data[gi*64 +: 64];
            if (keep) exp_q.push_back('{cyc + LAT + 2, eg, core_fn(last_key, last_data)});
        end
        if (do_rst) rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        if (do_rst) begin
            exp_q.delete();
            last_key  = '0;
            last_data = '0;
        end
        chk("core_invalid", 64'(core_invalid), 64'(gi >= 0 && !do_rst));
        chk("core_key", core_key, last_key);
        chk("core_id", core_id, last_data);
    endtask

    initial begin
        int t;
        rst      = 1'b1;
        req      = '0;
        req_key  = '0;
        req_data = '0;
        tbl = '{
            '{4'b0000, 4'b0000}, '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
            '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
            '{4'b1111, 4'b1000}, '{4'b0100, 4'b0100}, '{4'b1001, 4'b1000}, '{4'b1001, 4'b0001},
            '{4'b0011, 4'b0010}, '{4'b0101, 4'b0100}, '{4'b1001, 4'b1000}, '{4'b0000, 4'b0000},
            '{4'b1010, 4'b0010}, '{4'b0011, 4'b0001}, '{4'b0000, 4'b0000}
        };

        repeat (3) tick();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_core_invalid", 64'(core_invalid), 64'd0);
        chk("rst_core_key", core_key, 64'd0);
        chk("rst_core_id", core_id, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Arbitration table: contention from ptr=0, then wrap-around from ptr=3.
        for (int v = 0; v < 19; v++) begin
            set_lanes(v);
            drive(tbl[v].r, tbl[v].g, 1'b0, 1'b1);
        end
        repeat (LAT + 4) tick();

        // Known DES vector on requester 2, result due 18 cycles after the grant.
        set_lanes(99);
        req_key[2*64 +: 64]  = 64'h133457799BBCDFF1;
        req_data[2*64 +: 64] = 64'h0123456789ABCDEF;
        drive(4'b0100, 4'b0100, 1'b0, 1'b1);
        repeat (LAT + 4) tick();

        // Reset lands on the third issue; the two in flight must never answer.
        set_lanes(40);
        drive(4'b0001, 4'b0001, 1'b0, 1'b1);
        drive(4'b0010, 4'b0010, 1'b0, 1'b1);
        drive(4'b0100, 4'b0100, 1'b1, 1'b1);
        repeat (LAT + 4) tick();

        // Core drops the outvalid of the first block; the second still returns.
        set_lanes(50);
        t        = cyc;
        drop_cyc = cyc + 1;
        drive(4'b1000, 4'b1000, 1'b0, 1'b0);
        drive(4'b0001, 4'b0001, 1'b0, 1'b1);
        while (cyc < t + 2 + LAT) tick();
`ifdef DES_SCHED_CHECK_EN
        exp_err = 1'b1;
`endif
        repeat (LAT) tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        exp_err = 1'b0;
        exp_q.delete();
        repeat (LAT + 3) tick();

        chk("exp_left", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
